// File: rtl/ps2_mouse_packet_pkg.sv
// Shared constants for the PS/2 mouse packet framer: FSM states, bank
// word addresses and STATUS bit positions.
package ps2_mouse_packet_pkg;

  typedef enum logic [1:0] {
    ST_B0 = 2'd0,
    ST_B1 = 2'd1,
    ST_B2 = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_XPOS   = 2'd1;
  localparam logic [1:0] ADDR_YPOS   = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int STAT_NEW = 7;
  localparam int STAT_OVF = 4;

endpackage

// File: rtl/ps2_mouse_packet.sv
// Frames PS/2 mouse bytes into 3-byte packets, tracks a saturated cursor
// position and button state, and exposes them as a 4-word register bank.
module ps2_mouse_packet
  import ps2_mouse_packet_pkg::*;
#(
  parameter int XMAX    = 640,
  parameter int YMAX    = 480,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rxdata_i,
  input  logic        rxvalid_i,
  input  logic        rxerr_i,
  input  logic        wr_i,
  input  logic        rd_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q;
  logic [7:0]    b0_q, b1_q;
  logic [TW-1:0] tmo_q;
  logic [9:0]    x_q, y_q, x_d, y_d;
  logic [2:0]    btn_q;
  logic          new_q, ovf_q;
  logic [15:0]   pktcnt_q, errcnt_q;

  function automatic logic [9:0] clamp(input logic signed [11:0] v, input int mx);
    int vi;
    vi = int'(v);
    if (vi < 0)       return 10'd0;
    else if (vi > mx) return 10'(mx);
    else              return v[9:0];
  endfunction

  logic               accept, commit, drop, tmo_hit, err_ev, ovf_pkt;
  logic               wr_x, wr_y, wr_stat, cnt_clr, new_clr, ovf_clr;
  logic signed [11:0] dx, dy, x_sum, y_sum;

  assign accept  = rxvalid_i && !rxerr_i;
  assign commit  = accept && (state_q == ST_B2);
  assign drop    = accept && (state_q == ST_B0) && !rxdata_i[3];
  assign tmo_hit = (state_q != ST_B0) && !rxerr_i && !rxvalid_i &&
                   (tmo_q == TW'(TIMEOUT - 1));
  assign err_ev  = rxerr_i || drop || tmo_hit;
  assign ovf_pkt = b0_q[7] || b0_q[6];

  // b2 is consumed straight off the bus; 12-bit signed math avoids wrap
  assign dx    = {{4{b0_q[4]}}, b1_q};
  assign dy    = {{4{b0_q[5]}}, rxdata_i};
  assign x_sum = $signed({2'b00, x_q}) + dx;
  assign y_sum = $signed({2'b00, y_q}) - dy;

  assign wr_x    = wr_i && (addr_i == ADDR_XPOS);
  assign wr_y    = wr_i && (addr_i == ADDR_YPOS);
  assign wr_stat = wr_i && (addr_i == ADDR_STATUS);
  assign cnt_clr = wr_i && (addr_i == ADDR_COUNT);
  assign new_clr = (rd_i && (addr_i == ADDR_STATUS)) || (wr_stat && wdata_i[STAT_NEW]);
  assign ovf_clr = wr_stat && wdata_i[STAT_OVF];

  // Bus writes override the packet update for the same axis
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (commit && !ovf_pkt) begin
      x_d = clamp(x_sum, XMAX - 1);
      y_d = clamp(y_sum, YMAX - 1);
    end
    if (wr_x) x_d = clamp($signed({2'b00, wdata_i[9:0]}), XMAX - 1);
    if (wr_y) y_d = clamp($signed({2'b00, wdata_i[9:0]}), YMAX - 1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_B0;
      b0_q     <= '0;
      b1_q     <= '0;
      tmo_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      btn_q    <= '0;
      new_q    <= 1'b0;
      ovf_q    <= 1'b0;
      pktcnt_q <= '0;
      errcnt_q <= '0;
    end else begin
      if (rxerr_i) begin
        state_q <= ST_B0;
        tmo_q   <= '0;
      end else if (rxvalid_i) begin
        tmo_q <= '0;
        case (state_q)
          ST_B0: if (rxdata_i[3]) begin
            b0_q    <= rxdata_i;
            state_q <= ST_B1;
          end
          ST_B1: begin
            b1_q    <= rxdata_i;
            state_q <= ST_B2;
          end
          default: state_q <= ST_B0;
        endcase
      end else if (state_q == ST_B0) begin
        tmo_q <= '0;
      end else if (tmo_hit) begin
        state_q <= ST_B0;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end

      x_q <= x_d;
      y_q <= y_d;
      if (commit) btn_q <= b0_q[2:0];

      if (commit)       new_q <= 1'b1;
      else if (new_clr) new_q <= 1'b0;

      if (commit && ovf_pkt) ovf_q <= 1'b1;
      else if (ovf_clr)      ovf_q <= 1'b0;

      if (cnt_clr)     pktcnt_q <= '0;
      else if (commit) pktcnt_q <= pktcnt_q + 1'b1;

      if (cnt_clr)     errcnt_q <= '0;
      else if (err_ev) errcnt_q <= errcnt_q + 1'b1;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      ADDR_STATUS: begin
        rdata_o[STAT_NEW] = new_q;
        rdata_o[STAT_OVF] = ovf_q;
        rdata_o[2:0]      = btn_q;
      end
      ADDR_XPOS:  rdata_o[9:0] = x_q;
      ADDR_YPOS:  rdata_o[9:0] = y_q;
      default:    rdata_o      = {errcnt_q, pktcnt_q};
    endcase
  end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Scoreboard bench: a behavioural cursor model pushes expected register
// images when a packet is sent; they are popped and compared after commit.
module tb_ps2_mouse_packet;

  localparam int XMAX    = 640;
  localparam int YMAX    = 480;
  localparam int TIMEOUT = 400;

  logic        clk, rst;
  logic [7:0]  rxdata;
  logic        rxvalid, rxerr, wr, rd;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;

  int checks = 0;
  int failures = 0;

  ps2_mouse_packet #(.XMAX(XMAX), .YMAX(YMAX), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .rxdata_i(rxdata), .rxvalid_i(rxvalid),
    .rxerr_i(rxerr), .wr_i(wr), .rd_i(rd), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] status, xpos, ypos, count;
  } exp_t;
  exp_t sbq[$];

  int   mx, my, mpkt, merr;
  logic [2:0] mbtn;
  bit   mnew, movf;

  function automatic int sat(input int v, input int mxv);
    if (v < 0) return 0;
    if (v > mxv) return mxv;
    return v;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mpkt = 0; merr = 0; mbtn = 3'b000; mnew = 0; movf = 0;
    sbq.delete();
  endtask

  task automatic model_commit(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int dx, dy;
    dx = b0[4] ? int'(b1) - 256 : int'(b1);
    dy = b0[5] ? int'(b2) - 256 : int'(b2);
    mbtn = b0[2:0];
    mnew = 1;
    mpkt = (mpkt + 1) % 65536;
    if (b0[6] || b0[7]) movf = 1;
    else begin
      mx = sat(mx + dx, XMAX - 1);
      my = sat(my - dy, YMAX - 1);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.status = {24'b0, mnew, 2'b00, movf, 1'b0, mbtn};
    e.xpos   = 32'(mx);
    e.ypos   = 32'(my);
    e.count  = {16'(merr), 16'(mpkt)};
    sbq.push_back(e);
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic srd, input logic swr,
                           input logic [1:0] sa, input logic [31:0] swd);
    @(posedge clk); #1;
    rxdata = b; rxvalid = 1'b1; rd = srd; wr = swr;
    if (srd || swr) begin addr = sa; wdata = swd; end
    @(posedge clk); #1;
    rxvalid = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 0, 0, 2'd0, 32'd0);
    send_byte(b1, 0, 0, 2'd0, 32'd0);
    send_byte(b2, 0, 0, 2'd0, 32'd0);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    @(posedge clk); #1;
    rd = 1'b1; addr = a;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name);
    exp_t e;
    logic [31:0] s, x, y, c;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, no expected entry", name);
      return;
    end
    e = sbq.pop_front();
    @(negedge clk);
    read_reg(2'd0, s); read_reg(2'd1, x); read_reg(2'd2, y); read_reg(2'd3, c);
    if (s !== e.status) begin failures++; $display("FAIL %s.status: got %h expected %h", name, s, e.status); end
    checks++;
    if (x !== e.xpos) begin failures++; $display("FAIL %s.xpos: got %0d expected %0d", name, x, e.xpos); end
    checks++;
    if (y !== e.ypos) begin failures++; $display("FAIL %s.ypos: got %0d expected %0d", name, y, e.ypos); end
    checks++;
    if (c !== e.count) begin failures++; $display("FAIL %s.count: got %h expected %h", name, c, e.count); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rxdata = '0; rxvalid = 0; rxerr = 0; wr = 0; rd = 0; addr = '0; wdata = '0;
    idle(3);
    rst = 1'b0;
    model_reset();
    push_exp();
    check_out("reset");
  endtask

  task automatic test_basic();
    send_pkt(8'h08, 8'h05, 8'h03);
    model_commit(8'h08, 8'h05, 8'h03); push_exp();
    check_out("basic");
  endtask

  task automatic test_preset();
    logic [31:0] d;
    bus_write(2'd1, 32'd1000);
    read_reg(2'd1, d);
    checks++;
    if (d !== 32'd639) begin failures++; $display("FAIL preset_xclamp: got %0d expected 639", d); end
    bus_write(2'd2, 32'd700);
    read_reg(2'd2, d);
    checks++;
    if (d !== 32'd479) begin failures++; $display("FAIL preset_yclamp: got %0d expected 479", d); end
    bus_write(2'd1, 32'd100); mx = 100;
    bus_write(2'd2, 32'd100); my = 100;
    send_pkt(8'h39, 8'hFB, 8'hFE);
    model_commit(8'h39, 8'hFB, 8'hFE); push_exp();
    check_out("preset_pkt");
  endtask

  task automatic test_drop();
    bus_write(2'd3, 32'd0); mpkt = 0; merr = 0;
    send_byte(8'h00, 0, 0, 2'd0, 32'd0); merr++;
    send_pkt(8'h08, 8'h10, 8'h10);
    model_commit(8'h08, 8'h10, 8'h10); push_exp();
    check_out("drop");
  endtask

  task automatic test_timeout();
    send_byte(8'h08, 0, 0, 2'd0, 32'd0);
    send_byte(8'h01, 0, 0, 2'd0, 32'd0);
    idle(TIMEOUT + 100); merr++;
    send_pkt(8'h08, 8'h02, 8'h00);
    model_commit(8'h08, 8'h02, 8'h00); push_exp();
    check_out("timeout");
    send_byte(8'h08, 0, 0, 2'd0, 32'd0);
    idle(TIMEOUT / 2);
    send_byte(8'h04, 0, 0, 2'd0, 32'd0);
    idle(TIMEOUT / 2);
    send_byte(8'h00, 0, 0, 2'd0, 32'd0);
    model_commit(8'h08, 8'h04, 8'h00); push_exp();
    check_out("slow_gap");
  endtask

  task automatic test_overflow();
    logic [31:0] s;
    send_pkt(8'hC8, 8'hFF, 8'hFF);
    model_commit(8'hC8, 8'hFF, 8'hFF); push_exp();
    check_out("overflow");
    bus_read(2'd0);
    read_reg(2'd0, s);
    checks++;
    if (s !== 32'h10) begin failures++; $display("FAIL ovf_rdclr: got %h expected 00000010", s); end
    bus_write(2'd0, 32'h10); movf = 0; mnew = 0;
    read_reg(2'd0, s);
    checks++;
    if (s !== 32'h00) begin failures++; $display("FAIL ovf_wrclr: got %h expected 00000000", s); end
  endtask

  task automatic test_rxerr();
    send_byte(8'h08, 0, 0, 2'd0, 32'd0);
    @(posedge clk); #1;
    rxerr = 1'b1; rxvalid = 1'b1; rxdata = 8'h22;
    @(posedge clk); #1;
    rxerr = 1'b0; rxvalid = 1'b0;
    merr++;
    send_pkt(8'h08, 8'h01, 8'h00);
    model_commit(8'h08, 8'h01, 8'h00); push_exp();
    check_out("rxerr");
  endtask

  task automatic test_back_to_back();
    bus_write(2'd1, 32'd638); mx = 638;
    send_byte(8'h08, 0, 0, 2'd0, 32'd0);
    send_byte(8'h7F, 0, 0, 2'd0, 32'd0);
    send_byte(8'h00, 1, 0, 2'd0, 32'd0);
    model_commit(8'h08, 8'h7F, 8'h00); push_exp();
    check_out("rd_vs_commit");
    send_byte(8'h18, 0, 0, 2'd0, 32'd0);
    send_byte(8'hFF, 0, 0, 2'd0, 32'd0);
    send_byte(8'h00, 0, 1, 2'd3, 32'd0);
    model_commit(8'h18, 8'hFF, 8'h00); mpkt = 0; merr = 0; push_exp();
    check_out("cntclr_vs_commit");
    send_byte(8'h0B, 0, 0, 2'd0, 32'd0);
    send_byte(8'h05, 0, 0, 2'd0, 32'd0);
    send_byte(8'h00, 0, 1, 2'd1, 32'd7);
    model_commit(8'h0B, 8'h05, 8'h00); mx = 7; push_exp();
    check_out("xwr_vs_commit");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_preset();
    test_drop();
    test_timeout();
    test_overflow();
    test_rxerr();
    test_back_to_back();
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
